// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl
// Per-channel switch conditioning for board switches feeding board LEDs:
// two-flop synchroniser, debounce down to an accepted level (sw_state),
// registered rising-edge pulse (sw_rise) and a toggle latch per channel.
// The LED source is picked each cycle by mode: direct, toggle, blink, all-on.
// All flops use a synchronous active-low reset on rst_n.
//
// Optional feature, compiled in with `define SWITCH_LED_STANDBY_EN:
// adds a stdby input that freezes the debounce and blink counters, holds
// sw_state and the toggle latches, and forces sw_rise low and the LEDs off.
// The first edge that samples stdby low clears every debounce count, so a
// level change seen during standby is re-qualified from scratch.
module switch_led_ctrl #(
    parameter int NUM_CH         = 8,
    parameter int DEBOUNCE_CYC   = 20800,
    parameter int BLINK_HALF     = 1040000,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic              osc_clk,
    input  logic              rst_n,
`ifdef SWITCH_LED_STANDBY_EN
    input  logic              stdby,
`endif
    input  logic [NUM_CH-1:0] switch_in,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] sw_state,
    output logic [NUM_CH-1:0] sw_rise
);

    localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BL_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    localparam logic [NUM_CH-1:0] LED_OFF =
        (LED_ACTIVE_LOW != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_ALL_ON = 2'b11;

    // synchroniser
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;

    // debounce
    logic [NUM_CH-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [NUM_CH-1:0]           accept;

    // accepted level, rise pulse, toggle latch
    logic [NUM_CH-1:0] sw_state_q, sw_state_d;
    logic [NUM_CH-1:0] sw_rise_q, sw_rise_d;
    logic [NUM_CH-1:0] toggle_q, toggle_d;

    // shared blink timebase
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;

    // LED drive
    logic [NUM_CH-1:0] led_src;
    logic [NUM_CH-1:0] led_q, led_d;

    // run_en: counters advance and events are produced this edge.
    // wake:   first edge after standby; counts are cleared, nothing else moves.
    logic run_en;
    logic wake;

`ifdef SWITCH_LED_STANDBY_EN
    logic stdby_q, stdby_d;

    // Standby qualification: hold while stdby is high, clear on the way out.
    always_comb begin
        stdby_d = stdby;
        run_en  = !stdby && !stdby_q;
        wake    = !stdby && stdby_q;
    end

    // Remember last sampled stdby so the exit edge can be recognised.
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            stdby_q <= 1'b0;
        end else begin
            stdby_q <= stdby_d;
        end
    end
`else
    // Without standby the block is always running.
    always_comb begin
        run_en = 1'b1;
        wake   = 1'b0;
    end
`endif

    // Two-flop synchroniser for the asynchronous switch pins.
    always_comb begin
        sync1_d = switch_in;
        sync2_d = sync1_q;
    end

    // Debounce: count consecutive cycles where the synchronised level
    // differs from the accepted level; accept on the DEBOUNCE_CYC-th one.
    always_comb begin
        db_cnt_d = db_cnt_q;
        accept   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wake) begin
                db_cnt_d[i] = '0;
            end else if (run_en) begin
                if (sync2_q[i] == sw_state_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_cnt_d[i] = '0;
                    accept[i]   = 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Accepted level, rising-edge pulse and toggle latch, all on the accept edge.
    always_comb begin
        sw_state_d = sw_state_q ^ accept;
        sw_rise_d  = accept & sw_state_d;
        toggle_d   = toggle_q ^ sw_rise_d;
    end

    // Free-running blink counter; phase flips every BLINK_HALF cycles.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (run_en) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

    // LED source select from the values taking effect this edge, then polarity.
    always_comb begin
        led_src = '0;
        case (mode)
            MODE_DIRECT: led_src = sw_state_d;
            MODE_TOGGLE: led_src = toggle_d;
            MODE_BLINK:  led_src = sw_state_d & {NUM_CH{blink_ph_d}};
            MODE_ALL_ON: led_src = {NUM_CH{1'b1}};
            default:     led_src = '0;
        endcase
        if (run_en) begin
            led_d = led_src ^ LED_OFF;
        end else begin
            led_d = LED_OFF;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge osc_clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_cnt_q    <= '0;
            sw_state_q  <= '0;
            sw_rise_q   <= '0;
            toggle_q    <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            led_q       <= LED_OFF;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            sw_state_q  <= sw_state_d;
            sw_rise_q   <= sw_rise_d;
            toggle_q    <= toggle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            led_q       <= led_d;
        end
    end

    assign led      = led_q;
    assign sw_state = sw_state_q;
    assign sw_rise  = sw_rise_q;

endmodule
